// File: rtl/chrono_display_driver.sv
// BCD display driver: converts a 16-bit tenths-of-second count with a sequential
// double-dabble engine and scans it onto a 4-digit common-anode 7-segment display.
module chrono_display_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int DP_POS      = 1,
  parameter int BLANK_LZ    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        busy,
  output logic        ovf
);
  localparam int CW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_LOAD} state_t;

  state_t      r_state;
  logic [15:0] r_last;
  logic [15:0] r_shift;
  logic [19:0] r_bcd;
  logic [3:0]  r_iter;
  logic [15:0] r_disp;
  logic        r_busy;
  logic        r_ovf;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_dig;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic [19:0] w_adj;
  logic [35:0] w_next;
  logic [3:0]  w_nib;
  logic        w_blank;

  // add-3 correction on every nibble before the shift
  for (genvar g = 0; g < 5; g++) begin : g_adj
    assign w_adj[g*4 +: 4] = (r_bcd[g*4 +: 4] >= 4'd5) ? r_bcd[g*4 +: 4] + 4'd3
                                                       : r_bcd[g*4 +: 4];
  end
  assign w_next = {w_adj, r_shift} << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_last  <= '0;
      r_shift <= '0;
      r_bcd   <= '0;
      r_iter  <= '0;
      r_disp  <= '0;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (value != r_last) begin
          r_shift <= value;
          r_last  <= value;
          r_bcd   <= '0;
          r_iter  <= '0;
          r_busy  <= 1'b1;
          r_state <= S_CONV;
        end
        S_CONV: begin
          r_bcd   <= w_next[35:16];
          r_shift <= w_next[15:0];
          r_iter  <= r_iter + 4'd1;
          if (r_iter == 4'd15) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_disp  <= r_bcd[15:0];
          r_ovf   <= |r_bcd[19:16];
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  function automatic logic [6:0] seg_lut(input logic [3:0] n);
    case (n)
      4'd0:    seg_lut = 7'h40;
      4'd1:    seg_lut = 7'h79;
      4'd2:    seg_lut = 7'h24;
      4'd3:    seg_lut = 7'h30;
      4'd4:    seg_lut = 7'h19;
      4'd5:    seg_lut = 7'h12;
      4'd6:    seg_lut = 7'h02;
      4'd7:    seg_lut = 7'h78;
      4'd8:    seg_lut = 7'h00;
      4'd9:    seg_lut = 7'h10;
      default: seg_lut = 7'h7F;
    endcase
  endfunction

  // a digit is a leading zero when it and everything above it is zero
  always_comb begin
    w_nib   = r_disp[{r_dig, 2'b00} +: 4];
    w_blank = (BLANK_LZ != 0) && (int'(r_dig) > DP_POS) &&
              ((r_disp >> {r_dig, 2'b00}) == 16'h0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_dig <= '0;
      r_an  <= 4'hF;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else begin
      if (r_cnt == CW'(REFRESH_DIV - 1)) begin
        r_cnt <= '0;
        r_dig <= r_dig + 2'd1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_blank) begin
        r_an  <= 4'hF;
        r_seg <= 7'h7F;
        r_dp  <= 1'b1;
      end else begin
        r_an  <= ~(4'b0001 << r_dig);
        r_seg <= seg_lut(w_nib);
        r_dp  <= ~(int'(r_dig) == DP_POS);
      end
    end
  end

  assign an   = r_an;
  assign seg  = r_seg;
  assign dp   = r_dp;
  assign busy = r_busy;
  assign ovf  = r_ovf;
endmodule

// File: tb/tb_chrono_display_driver.sv
// Bench for chrono_display_driver: vector table, hand-built corner sequences and
// random values checked against a decimal-arithmetic display model.
module tb_chrono_display_driver;
  typedef logic [3:0][6:0] segs_t;
  typedef struct {
    int    v;
    int    busy_cyc;
    logic  ovf;
    segs_t segs;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  an, an2;
  logic [6:0]  seg, seg2;
  logic        dp, dp2, busy, busy2, ovf, ovf2;

  int checks = 0;
  int errors = 0;
  int n = 0;

  logic [6:0] lut[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int pw[4] = '{1, 10, 100, 1000};

  always #5 clk = ~clk;

  // edges since reset release, used to know which digit slot is on
  always @(posedge clk or posedge rst)
    if (rst) n <= 0;
    else     n <= n + 1;

  chrono_display_driver #(.REFRESH_DIV(4), .DP_POS(1), .BLANK_LZ(1)) dut (
    .clk(clk), .rst(rst), .value(value), .an(an), .seg(seg), .dp(dp), .busy(busy), .ovf(ovf));

  chrono_display_driver #(.REFRESH_DIV(4), .DP_POS(1), .BLANK_LZ(0)) dut_nb (
    .clk(clk), .rst(rst), .value(value), .an(an2), .seg(seg2), .dp(dp2), .busy(busy2), .ovf(ovf2));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] mseg(input int v, input int k, input bit blz);
    int d;
    d = v % 10000;
    if (blz && k > 1 && d < pw[k]) return 7'h7F;
    return lut[(d / pw[k]) % 10];
  endfunction

  function automatic segs_t msegs(input int v, input bit blz);
    segs_t s;
    for (int k = 0; k < 4; k++) s[k] = mseg(v, k, blz);
    return s;
  endfunction

  task automatic scan_check(input int v, input segs_t es, input int cyc);
    int k;
    logic [3:0] e_an;
    logic [6:0] e2;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      k = ((n - 1) / 4) % 4;
      e_an = 4'hF;
      if (es[k] != 7'h7F) e_an[k] = 1'b0;
      chk("an", an, e_an);
      chk("seg", seg, es[k]);
      chk("dp", dp, (k == 1 && es[k] != 7'h7F) ? 0 : 1);
      e2 = mseg(v, k, 1'b0);
      e_an = 4'hF;
      e_an[k] = 1'b0;
      chk("an_nb", an2, e_an);
      chk("seg_nb", seg2, e2);
      chk("dp_nb", dp2, (k == 1) ? 0 : 1);
      chk("ovf", ovf, (v > 9999) ? 1 : 0);
      chk("ovf_nb", ovf2, (v > 9999) ? 1 : 0);
    end
  endtask

  // counts consecutive busy-high samples starting at the current negedge
  task automatic count_busy(output int c);
    c = 0;
    while (busy === 1'b1 && c < 40) begin
      c++;
      @(negedge clk);
    end
  endtask

  task automatic apply(input int v, input int eb);
    int c;
    @(negedge clk);
    value = 16'(v);
    @(negedge clk);
    count_busy(c);
    chk("busy_cycles", c, eb);
    chk("busy_nb_low", busy2, 0);
  endtask

  vec_t tbl[8];

  initial begin
    int c, k, prev, v;
    segs_t es;
    tbl[0] = '{0,     0,  1'b0, {7'h7F, 7'h7F, 7'h40, 7'h40}};
    tbl[1] = '{1234,  17, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}};
    tbl[2] = '{1234,  0,  1'b0, {7'h79, 7'h24, 7'h30, 7'h19}};
    tbl[3] = '{5,     17, 1'b0, {7'h7F, 7'h7F, 7'h40, 7'h12}};
    tbl[4] = '{12345, 17, 1'b1, {7'h24, 7'h30, 7'h19, 7'h12}};
    tbl[5] = '{9999,  17, 1'b0, {7'h10, 7'h10, 7'h10, 7'h10}};
    tbl[6] = '{10000, 17, 1'b1, {7'h7F, 7'h7F, 7'h40, 7'h40}};
    tbl[7] = '{65535, 17, 1'b1, {7'h12, 7'h12, 7'h30, 7'h12}};

    repeat (3) @(negedge clk);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_an_nb", an2, 4'hF);
    rst = 1'b0;
    @(negedge clk);
    chk("first_an", an, 4'hE);
    chk("first_seg", seg, 7'h40);
    chk("first_dp", dp, 1);
    chk("first_busy", busy, 0);

    for (int i = 0; i < 8; i++) begin
      apply(tbl[i].v, tbl[i].busy_cyc);
      chk("ovf_tbl", ovf, tbl[i].ovf);
      scan_check(tbl[i].v, tbl[i].segs, 16);
    end

    // value changes mid-conversion: first result lands, then one more conversion
    @(negedge clk);
    value = 16'd100;
    @(negedge clk);
    chk("mid_busy_rise", busy, 1);
    repeat (4) @(negedge clk);
    value = 16'd200;
    count_busy(c);
    chk("mid_busy_tail", c, 13);
    chk("mid_gap_busy", busy, 0);
    @(negedge clk);
    chk("mid_second_rise", busy, 1);
    k = ((n - 1) / 4) % 4;
    es = msegs(100, 1'b1);
    chk("mid_show100", seg, es[k]);
    count_busy(c);
    chk("mid_second_len", c, 17);
    scan_check(200, msegs(200, 1'b1), 16);
    c = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) c++;
    end
    chk("mid_no_third", c, 0);

    // reset during the 8th conversion cycle
    @(negedge clk);
    value = 16'd777;
    @(negedge clk);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstc_an", an, 4'hF);
    chk("rstc_seg", seg, 7'h7F);
    chk("rstc_dp", dp, 1);
    chk("rstc_busy", busy, 0);
    chk("rstc_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    count_busy(c);
    chk("rstc_reconv", c, 17);
    scan_check(777, msegs(777, 1'b1), 16);

    prev = 777;
    for (int i = 0; i < 10; i++) begin
      case (i % 3)
        0:       v = int'($urandom_range(0, 65535));
        1:       v = int'($urandom_range(0, 99));
        default: v = int'($urandom_range(0, 9999));
      endcase
      if (i == 5) v = prev;
      apply(v, (v != prev) ? 17 : 0);
      scan_check(v, msegs(v, 1'b1), 16);
      prev = v;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
